// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with a 2-bit saturating
// counter per entry. Lookup is combinational on the fetch PC. Training comes
// from ID, one resolved control-transfer instruction per upd_en strobe.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   pred_pc           - fetch PC being looked up
//   pred_br_taken     - predicted taken (combinational)
//   pred_br_target    - predicted next PC (combinational, pred_pc+4 if not taken)
//   upd_en            - update strobe from ID
//   upd_inst_addr     - PC of the resolved instruction
//   upd_br_inst       - instruction is b/bl/jirl/beq/bne
//   upd_cond_br_inst  - instruction is beq/bne
//   upd_br_taken      - resolved direction
//   upd_br_target     - resolved taken target (low 2 bits ignored)
//   stat_lookups_hit  - accepted updates that hit an entry
//   stat_updates      - accepted updates
module branch_predictor #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pred_pc,
  output logic        pred_br_taken,
  output logic [31:0] pred_br_target,
  input  logic        upd_en,
  input  logic [31:0] upd_inst_addr,
  input  logic        upd_br_inst,
  input  logic        upd_cond_br_inst,
  input  logic        upd_br_taken,
  input  logic [31:0] upd_br_target,
  output logic [31:0] stat_lookups_hit,
  output logic [31:0] stat_updates
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;

  // Entry storage (flops)
  logic             valid_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q     [ENTRIES];
  logic [29:0]      target_q  [ENTRIES];
  logic             is_cond_q [ENTRIES];
  logic [1:0]       ctr_q     [ENTRIES];

  // Lookup side
  logic [IDX_W-1:0] pred_idx;
  logic [TAG_W-1:0] pred_tag;
  logic             pred_hit;

  assign pred_idx = pred_pc[IDX_W+1:2];
  assign pred_tag = pred_pc[31:IDX_W+2];
  assign pred_hit = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);

  // Unconditional branches that hit are always taken; conditionals use ctr MSB
  assign pred_br_taken  = pred_hit && (!is_cond_q[pred_idx] || ctr_q[pred_idx][1]);
  assign pred_br_target = pred_br_taken ? {target_q[pred_idx], 2'b00}
                                        : pred_pc + 32'd4;

  // Update side
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_accept;
  logic             upd_hit;
  logic [1:0]       ctr_next;

  assign upd_idx    = upd_inst_addr[IDX_W+1:2];
  assign upd_tag    = upd_inst_addr[31:IDX_W+2];
  assign upd_accept = upd_en && upd_br_inst;
  assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Saturating counter step on a hit; unconditional branches leave it alone
  always_comb begin
    ctr_next = ctr_q[upd_idx];
    if (upd_cond_br_inst) begin
      if (upd_br_taken && (ctr_q[upd_idx] != 2'b11)) begin
        ctr_next = ctr_q[upd_idx] + 2'd1;
      end else if (!upd_br_taken && (ctr_q[upd_idx] != 2'b00)) begin
        ctr_next = ctr_q[upd_idx] - 2'd1;
      end
    end
  end

  // Byte-offset bits carry no information for word-aligned instructions
  logic unused_low_bits;
  assign unused_low_bits = ^{pred_pc[1:0], upd_inst_addr[1:0], upd_br_target[1:0]};

  // Table training and statistics; reset takes priority over a pending update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[IDX_W'(i)] <= 1'b0;
        ctr_q[IDX_W'(i)]   <= 2'b01;
      end
      stat_lookups_hit <= 32'd0;
      stat_updates     <= 32'd0;
    end else if (upd_accept) begin
      stat_updates <= stat_updates + 32'd1;
      if (upd_hit) begin
        stat_lookups_hit   <= stat_lookups_hit + 32'd1;
        is_cond_q[upd_idx] <= upd_cond_br_inst;
        ctr_q[upd_idx]     <= ctr_next;
        if (upd_br_taken) begin
          target_q[upd_idx] <= upd_br_target[31:2];
        end
      end else if (upd_br_taken) begin
        // Allocate, evicting whatever aliases to this index
        valid_q[upd_idx]   <= 1'b1;
        tag_q[upd_idx]     <= upd_tag;
        target_q[upd_idx]  <= upd_br_target[31:2];
        is_cond_q[upd_idx] <= upd_cond_br_inst;
        ctr_q[upd_idx]     <= upd_cond_br_inst ? 2'b10 : 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, allocation, counter training
// and saturation, unconditional branches, aliasing, read-before-write and
// reset/update collision.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] pred_pc;
  logic        pred_br_taken;
  logic [31:0] pred_br_target;
  logic        upd_en;
  logic [31:0] upd_inst_addr;
  logic        upd_br_inst;
  logic        upd_cond_br_inst;
  logic        upd_br_taken;
  logic [31:0] upd_br_target;
  logic [31:0] stat_lookups_hit;
  logic [31:0] stat_updates;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.IDX_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .pred_pc          (pred_pc),
    .pred_br_taken    (pred_br_taken),
    .pred_br_target   (pred_br_target),
    .upd_en           (upd_en),
    .upd_inst_addr    (upd_inst_addr),
    .upd_br_inst      (upd_br_inst),
    .upd_cond_br_inst (upd_cond_br_inst),
    .upd_br_taken     (upd_br_taken),
    .upd_br_target    (upd_br_target),
    .stat_lookups_hit (stat_lookups_hit),
    .stat_updates     (stat_updates)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one update, let it be captured, then drop the strobe
  task automatic upd(input logic [31:0] addr, input logic br, input logic cond,
                     input logic taken, input logic [31:0] tgt);
    upd_inst_addr    = addr;
    upd_br_inst      = br;
    upd_cond_br_inst = cond;
    upd_br_taken     = taken;
    upd_br_target    = tgt;
    upd_en           = 1'b1;
    @(posedge clk);
    #1;
    upd_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pred_pc = 32'h1c000000;
    #1;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b0, 32'h1c000004}) begin
      errors++;
      $display("FAIL reset_lookup got %0b/%h exp 0/1c000004", pred_br_taken, pred_br_target);
    end
    checks++;
    if ({stat_updates, stat_lookups_hit} !== 64'd0) begin
      errors++;
      $display("FAIL reset_stats got %0d/%0d exp 0/0", stat_updates, stat_lookups_hit);
    end
    pred_pc = 32'hfffffffc;
    #1;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b0, 32'h00000000}) begin
      errors++;
      $display("FAIL pc_wrap got %0b/%h exp 0/00000000", pred_br_taken, pred_br_target);
    end
  endtask

  task automatic test_alloc;
    upd(32'h1c000010, 1'b1, 1'b1, 1'b1, 32'h1c000040);
    pred_pc = 32'h1c000010;
    #1;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b1, 32'h1c000040}) begin
      errors++;
      $display("FAIL alloc_lookup got %0b/%h exp 1/1c000040", pred_br_taken, pred_br_target);
    end
    checks++;
    if ({stat_updates, stat_lookups_hit} !== {32'd1, 32'd0}) begin
      errors++;
      $display("FAIL alloc_stats got %0d/%0d exp 1/0", stat_updates, stat_lookups_hit);
    end
  endtask

  task automatic test_counter;
    // ctr 10 -> 01: weakly not taken
    upd(32'h1c000010, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checks++;
    if (pred_br_taken !== 1'b0) begin
      errors++;
      $display("FAIL ctr_01 got %0b exp 0", pred_br_taken);
    end
    // ctr 01 -> 00, then stays 00
    upd(32'h1c000010, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b0, 32'h1c000014}) begin
      errors++;
      $display("FAIL ctr_00 got %0b/%h exp 0/1c000014", pred_br_taken, pred_br_target);
    end
    upd(32'h1c000010, 1'b1, 1'b1, 1'b0, 32'h0);
    // ctr 00 -> 01: still not taken if floor held
    upd(32'h1c000010, 1'b1, 1'b1, 1'b1, 32'h1c000040);
    #1;
    checks++;
    if (pred_br_taken !== 1'b0) begin
      errors++;
      $display("FAIL ctr_floor got %0b exp 0", pred_br_taken);
    end
    // ctr 01 -> 10 -> 11 (with new target) -> 11
    upd(32'h1c000010, 1'b1, 1'b1, 1'b1, 32'h1c000040);
    #1;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b1, 32'h1c000040}) begin
      errors++;
      $display("FAIL ctr_10 got %0b/%h exp 1/1c000040", pred_br_taken, pred_br_target);
    end
    upd(32'h1c000010, 1'b1, 1'b1, 1'b1, 32'h1c000080);
    upd(32'h1c000010, 1'b1, 1'b1, 1'b1, 32'h1c000080);
    #1;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b1, 32'h1c000080}) begin
      errors++;
      $display("FAIL ctr_11 got %0b/%h exp 1/1c000080", pred_br_taken, pred_br_target);
    end
    // ctr 11 -> 10: still taken if ceiling held; target unchanged by not-taken
    upd(32'h1c000010, 1'b1, 1'b1, 1'b0, 32'h1c000999);
    #1;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b1, 32'h1c000080}) begin
      errors++;
      $display("FAIL ctr_ceiling got %0b/%h exp 1/1c000080", pred_br_taken, pred_br_target);
    end
    checks++;
    if ({stat_updates, stat_lookups_hit} !== {32'd9, 32'd8}) begin
      errors++;
      $display("FAIL counter_stats got %0d/%0d exp 9/8", stat_updates, stat_lookups_hit);
    end
  endtask

  task automatic test_uncond;
    upd(32'h1c000020, 1'b1, 1'b0, 1'b1, 32'h1c000100);
    upd(32'h1c000020, 1'b1, 1'b0, 1'b0, 32'h0);
    upd(32'h1c000020, 1'b1, 1'b0, 1'b0, 32'h0);
    pred_pc = 32'h1c000020;
    #1;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b1, 32'h1c000100}) begin
      errors++;
      $display("FAIL uncond_lookup got %0b/%h exp 1/1c000100", pred_br_taken, pred_br_target);
    end
    // Non-branch update and idle strobe must change nothing
    upd(32'h1c000020, 1'b0, 1'b0, 1'b1, 32'h1c000500);
    upd_inst_addr = 32'h1c000024;
    upd_br_inst   = 1'b1;
    upd_br_taken  = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({stat_updates, stat_lookups_hit} !== {32'd12, 32'd10}) begin
      errors++;
      $display("FAIL uncond_stats got %0d/%0d exp 12/10", stat_updates, stat_lookups_hit);
    end
    pred_pc = 32'h1c000024;
    #1;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b0, 32'h1c000028}) begin
      errors++;
      $display("FAIL idle_no_alloc got %0b/%h exp 0/1c000028", pred_br_taken, pred_br_target);
    end
  endtask

  task automatic test_alias;
    upd(32'h1c000050, 1'b1, 1'b1, 1'b1, 32'h1c000200);
    pred_pc = 32'h1c000010;
    #1;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b0, 32'h1c000014}) begin
      errors++;
      $display("FAIL alias_evicted got %0b/%h exp 0/1c000014", pred_br_taken, pred_br_target);
    end
    upd(32'h1c000090, 1'b1, 1'b1, 1'b0, 32'h1c000400);
    pred_pc = 32'h1c000050;
    #1;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b1, 32'h1c000200}) begin
      errors++;
      $display("FAIL alias_kept got %0b/%h exp 1/1c000200", pred_br_taken, pred_br_target);
    end
    pred_pc = 32'h1c000090;
    #1;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b0, 32'h1c000094}) begin
      errors++;
      $display("FAIL alias_nt_miss got %0b/%h exp 0/1c000094", pred_br_taken, pred_br_target);
    end
    checks++;
    if ({stat_updates, stat_lookups_hit} !== {32'd14, 32'd10}) begin
      errors++;
      $display("FAIL alias_stats got %0d/%0d exp 14/10", stat_updates, stat_lookups_hit);
    end
  endtask

  task automatic test_same_cycle;
    @(negedge clk);
    pred_pc          = 32'h1c000030;
    upd_inst_addr    = 32'h1c000030;
    upd_br_inst      = 1'b1;
    upd_cond_br_inst = 1'b0;
    upd_br_taken     = 1'b1;
    upd_br_target    = 32'h1c000303;
    upd_en           = 1'b1;
    #1;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b0, 32'h1c000034}) begin
      errors++;
      $display("FAIL same_cycle_old got %0b/%h exp 0/1c000034", pred_br_taken, pred_br_target);
    end
    @(posedge clk);
    #1;
    upd_en = 1'b0;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b1, 32'h1c000300}) begin
      errors++;
      $display("FAIL same_cycle_new got %0b/%h exp 1/1c000300", pred_br_taken, pred_br_target);
    end
  endtask

  task automatic test_reset_collision;
    upd_inst_addr    = 32'h1c000070;
    upd_br_inst      = 1'b1;
    upd_cond_br_inst = 1'b1;
    upd_br_taken     = 1'b1;
    upd_br_target    = 32'h1c000700;
    upd_en           = 1'b1;
    reset            = 1'b1;
    @(posedge clk);
    #1;
    upd_en = 1'b0;
    reset  = 1'b0;
    checks++;
    if ({stat_updates, stat_lookups_hit} !== 64'd0) begin
      errors++;
      $display("FAIL collision_stats got %0d/%0d exp 0/0", stat_updates, stat_lookups_hit);
    end
    pred_pc = 32'h1c000070;
    #1;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b0, 32'h1c000074}) begin
      errors++;
      $display("FAIL collision_drop got %0b/%h exp 0/1c000074", pred_br_taken, pred_br_target);
    end
    pred_pc = 32'h1c000050;
    #1;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b0, 32'h1c000054}) begin
      errors++;
      $display("FAIL collision_flush50 got %0b/%h exp 0/1c000054", pred_br_taken, pred_br_target);
    end
    pred_pc = 32'h1c000030;
    #1;
    checks++;
    if ({pred_br_taken, pred_br_target} !== {1'b0, 32'h1c000034}) begin
      errors++;
      $display("FAIL collision_flush30 got %0b/%h exp 0/1c000034", pred_br_taken, pred_br_target);
    end
  endtask

  initial begin
    reset            = 1'b0;
    pred_pc          = 32'h0;
    upd_en           = 1'b0;
    upd_inst_addr    = 32'h0;
    upd_br_inst      = 1'b0;
    upd_cond_br_inst = 1'b0;
    upd_br_taken     = 1'b0;
    upd_br_target    = 32'h0;
    test_reset;
    test_alloc;
    test_counter;
    test_uncond;
    test_alias;
    test_same_cycle;
    test_reset_collision;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-side direct-mapped BTB plus 2-bit saturating-counter BHT.
- Provides a same-cycle taken/target prediction for the fetch PC; IF carries the taken bit to ID in if_to_id_bus[64].
- Trained by ID through the upd_* interface. ID resolves the branch and redirects fetch only when the resolved outcome differs from this prediction.

Parameters:
- IDX_W, 4, index width; entry count = 2**IDX_W; index = pc[IDX_W+1:2]
- TAG_W, 30-IDX_W, tag width; tag = pc[31:IDX_W+2]

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- pred_pc  in  32  fetch PC being looked up
- pred_br_taken  out  1  predicted taken
- pred_br_target  out  32  predicted next PC (pred_pc+4 when not taken)
- upd_en  in  1  update strobe; one resolved control-transfer instruction
- upd_inst_addr  in  32  PC of resolved instruction
- upd_br_inst  in  1  instruction is b/bl/jirl/beq/bne
- upd_cond_br_inst  in  1  instruction is beq/bne
- upd_br_taken  in  1  resolved direction
- upd_br_target  in  32  resolved taken target
- stat_lookups_hit  out  32  count of updates whose entry hit
- stat_updates  out  32  count of accepted updates

Behaviour:
- Storage per entry:
  - valid (1)
  - tag (TAG_W)
  - target (30; word address, low 2 bits implied 00)
  - is_cond (1)
  - ctr (2)
- Storage is flop-based; no RAM.

Reset (synchronous):
- All valid bits = 0; all ctr = 2'b01; stat counters = 0.
- Consequently pred_br_taken = 0 and pred_br_target = pred_pc+4 in the cycle after reset is sampled.
- Tag/target/is_cond contents are don't-care while valid = 0.

Lookup (combinational, zero latency):
- hit = valid[idx] && tag[idx] == pred_pc tag field.
- pred_br_taken = hit && (!is_cond[idx] || ctr[idx][1]).
- pred_br_target = pred_br_taken ? {target[idx], 2'b00} : pred_pc + 32'd4 (32-bit wrap).

Update (registered; written at the posedge where upd_en=1):
- Accepted only if upd_en && upd_br_inst; otherwise no state change and no stat increment.
- Hit case (same tag): valid stays 1; is_cond <= upd_cond_br_inst.
  - Conditional: ctr saturating +1 if taken, -1 if not; no wrap at 3 or 0.
  - Unconditional: ctr unchanged.
  - If upd_br_taken: target <= upd_br_target[31:2].
- Miss and upd_br_taken:
  - Allocate, overwriting any occupant.
  - valid <= 1, tag, target, is_cond written.
  - ctr <= 2'b10 for conditional; ctr <= 2'b11 for unconditional.
- Miss and not taken: no allocation; table unchanged.
- Stats:
  - stat_updates += 1 per accepted update.
  - stat_lookups_hit += 1 when the accepted update hit.
  - Both wrap modulo 2^32.

Timing and corner rules:
- No write-to-read bypass. A lookup in the same cycle as an update to the same index sees old contents; the new contents are visible from the next cycle.
- Simultaneous reset and upd_en: reset wins; the update is dropped.
- Aliasing (same index, different tag): the allocating taken branch evicts the occupant. A not-taken alias never evicts.
- upd_br_target[1:0] is ignored; all targets are word aligned.

Test Plan:
- Reset, then lookup pred_pc=0x1c000000 -> pred_br_taken=0, pred_br_target=0x1c000004.
- Update bne at 0x1c000010, taken, target 0x1c000040. Next cycle lookup 0x1c000010 -> taken=1, target=0x1c000040; stat_updates=1, stat_lookups_hit=0.
- Same bne, then two not-taken updates -> ctr 10->01->00; lookup -> taken=0, target=0x1c000014. Third not-taken keeps ctr=00. Three taken updates -> ctr 01,10,11; lookup taken=1.
- Update b at 0x1c000020, taken, target 0x1c000100; then a not-taken-typed update on it -> still predicted taken (ctr ignored for unconditional).
- Alias with IDX_W=4: entry at 0x1c000010 valid, taken update at 0x1c000050 (same idx 4) -> lookup 0x1c000010 misses (taken=0), 0x1c000050 hits. A not-taken miss update at 0x1c000090 leaves 0x1c000050 intact.
- Same-cycle lookup/update to 0x1c000030 (first taken update) -> that cycle taken=0, next cycle taken=1. reset and upd_en asserted together -> table empty afterwards, stats 0.
